// File: rtl/uart_pkg.sv
// Shared UART types, parity-mode constants and frame-size helper.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Number of sampled bits after the start bit: data + optional parity + stop.
  function automatic int unsigned uart_frame_bits(input int unsigned data,
                                                  input int unsigned parity,
                                                  input int unsigned stop);
    return data + ((parity != PARITY_NONE) ? 32'd1 : 32'd0) + stop;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the asynchronous input; both stages reset to RST_VAL.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with parity/framing status and a one-entry
// valid/ready holding register with overrun detection.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned NUM_CLKS_PER_BIT = 62,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY_MODE      = 0,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned MID   = (NUM_CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W = $clog2(NUM_CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(NUM_CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

  if (NUM_CLKS_PER_BIT < 4) begin : g_chk_clks
    $error("uart_rx_cfg: NUM_CLKS_PER_BIT must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE > PARITY_ODD) begin : g_chk_par
    $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (uart_frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS) > 12) begin : g_chk_frame
    $error("uart_rx_cfg: frame too long");
  end

  logic s;

  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx_serial),
    .q_o   (s)
  );

  uart_rx_state_t       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 busy_q;
  logic [1:0]           settle_q;

  logic [DATA_BITS-1:0] dout_q;
  logic                 valid_q;
  logic                 perr_out_q;
  logic                 ferr_out_q;
  logic                 ovr_q;

  logic ferr_final;
  logic brk;
  logic done;
  logic par_calc;

  // Frame-level combinational status at the final stop sample.
  always_comb begin
    ferr_final = ferr_q | ~s;
    brk        = ferr_final && (data_q == '0);
    done       = (state_q == STOP) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST_STOP);
    par_calc   = (^data_q) ^ s;
  end

  // Receive FSM: bit timing, sampling and per-frame status accumulation.
  // settle_q holds off WAIT_HIGH until the synchroniser reset value has been
  // flushed, so a line held low across reset release cannot look idle.
  // Data is shifted in from the top so that after DATA_BITS samples the
  // first data bit sits at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_HIGH;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      if (!settle_q[1]) settle_q <= settle_q + 2'd1;
      case (state_q)
        WAIT_HIGH: begin
          if (settle_q[1] && s) state_q <= IDLE;
        end
        IDLE: begin
          if (!s) begin
            state_q <= START;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (!s) begin
              state_q <= DATA;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            data_q <= {s, data_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST_DATA) begin
              idx_q   <= '0;
              state_q <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            perr_q  <= (PARITY_MODE == PARITY_ODD) ? ~par_calc : par_calc;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            ferr_q <= ferr_final;
            if (idx_q == IDX_LAST_STOP) begin
              idx_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= brk ? WAIT_HIGH : IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= WAIT_HIGH;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry holding register; a completed frame is dropped when full and not popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (valid_q && rx_ready) valid_q <= 1'b0;
      if (done) begin
        if (!valid_q || rx_ready) begin
          dout_q     <= data_q;
          perr_out_q <= perr_q;
          ferr_out_q <= ferr_final;
          valid_q    <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign rx_dout     = dout_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_out_q;
  assign frame_err   = ferr_out_q;
  assign overrun_err = ovr_q;
  assign rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1 (62 clk/bit), 8E1 and 9O2 (16 clk/bit).
module tb_uart_rx_cfg;

  localparam int NA    = 62;
  localparam int NB    = 16;
  localparam int LAT_A = 591;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ser = 3'b111;
  logic       rdy_a = 1'b1;
  logic       pop_pulse = 1'b0;
  logic       pop_armed = 1'b0;
  logic       rdy_full_a;

  logic [7:0] dout_a;
  logic       vld_a, perr_a, ferr_a, ovr_a, busy_a;
  logic [7:0] dout_b;
  logic       vld_b, perr_b, ferr_b, ovr_b, busy_b;
  logic [8:0] dout_c;
  logic       vld_c, perr_c, ferr_c, ovr_c, busy_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_e0 = 0;
  int rise_a = 0;
  int ovr_cyc_a = 0;
  int pops_a = 0;
  int ovr_cnt_a = 0;
  int vhi_a = 0;
  int busy_cnt_a = 0;
  logic prev_vld_a = 1'b0;
  int snap, snap2;

  assign rdy_full_a = rdy_a | pop_pulse;

  always #5 clk = ~clk;

  uart_rx_cfg #(.NUM_CLKS_PER_BIT(NA), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx_serial(ser[0]), .rx_dout(dout_a), .rx_valid(vld_a),
    .rx_ready(rdy_full_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun_err(ovr_a), .rx_busy(busy_a));

  uart_rx_cfg #(.NUM_CLKS_PER_BIT(NB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .rx_serial(ser[1]), .rx_dout(dout_b), .rx_valid(vld_b),
    .rx_ready(1'b1), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun_err(ovr_b), .rx_busy(busy_b));

  uart_rx_cfg #(.NUM_CLKS_PER_BIT(NB), .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rx_serial(ser[2]), .rx_dout(dout_c), .rx_valid(vld_c),
    .rx_ready(1'b1), .parity_err(perr_c), .frame_err(ferr_c),
    .overrun_err(ovr_c), .rx_busy(busy_c));

  // Cycle counter: value equals the number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Pops of receiver A happen on the rising edge where valid and ready are both high.
  always @(posedge clk) if (vld_a && rdy_full_a) pops_a <= pops_a + 1;

  // Mid-cycle observation of receiver A and the timed pop request.
  always @(negedge clk) begin
    pop_pulse <= pop_armed && (cyc + 1 == last_e0 + LAT_A);
    if (vld_a && !prev_vld_a) rise_a <= cyc;
    prev_vld_a <= vld_a;
    if (vld_a) vhi_a <= vhi_a + 1;
    if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
    if (ovr_a) begin
      ovr_cnt_a <= ovr_cnt_a + 1;
      ovr_cyc_a <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame LSB first: start, data, optional parity, stop bits, one idle bit.
  task automatic send(input int sel, input logic [8:0] d, input int nd,
                      input bit has_par, input logic pbit,
                      input int nstop, input logic [1:0] stops, input int n);
    @(negedge clk);
    ser[sel] = 1'b0;
    last_e0  = cyc + 1;
    idle(n);
    for (int i = 0; i < nd; i++) begin
      ser[sel] = d[i];
      idle(n);
    end
    if (has_par) begin
      ser[sel] = pbit;
      idle(n);
    end
    for (int i = 0; i < nstop; i++) begin
      ser[sel] = stops[i];
      idle(n);
    end
    ser[sel] = 1'b1;
    idle(n);
  endtask

  initial begin
    idle(3);
    check("rst_dout",  32'(dout_a), 32'h0);
    check("rst_valid", 32'(vld_a),  32'h0);
    check("rst_perr",  32'(perr_a), 32'h0);
    check("rst_ferr",  32'(ferr_a), 32'h0);
    check("rst_ovr",   32'(ovr_a),  32'h0);
    check("rst_busy",  32'(busy_a), 32'h0);
    rst = 1'b0;
    idle(10);

    // 8N1 0xA5 with ready held high
    snap = pops_a;
    vhi_a = 0;
    send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11, NA);
    check("a5_latency", 32'(rise_a - last_e0), 32'(LAT_A));
    check("a5_dout",    32'(dout_a), 32'hA5);
    check("a5_perr",    32'(perr_a), 32'h0);
    check("a5_ferr",    32'(ferr_a), 32'h0);
    check("a5_ovr",     32'(ovr_cnt_a), 32'h0);
    check("a5_vhi",     32'(vhi_a), 32'h1);
    check("a5_pops",    32'(pops_a - snap), 32'h1);

    // 8E1
    send(1, 9'h007, 8, 1'b1, 1'b1, 1, 2'b11, NB);
    check("e_good_dout", 32'(dout_b), 32'h07);
    check("e_good_perr", 32'(perr_b), 32'h0);
    send(1, 9'h007, 8, 1'b1, 1'b0, 1, 2'b11, NB);
    check("e_bad_dout",  32'(dout_b), 32'h07);
    check("e_bad_perr",  32'(perr_b), 32'h1);
    check("e_bad_ferr",  32'(ferr_b), 32'h0);

    // 9O2
    send(2, 9'h1FF, 9, 1'b1, 1'b0, 2, 2'b11, NB);
    check("o_dout", 32'(dout_c), 32'h1FF);
    check("o_perr", 32'(perr_c), 32'h0);
    check("o_ferr", 32'(ferr_c), 32'h0);
    // second stop bit low: framing error on non-zero data
    send(2, 9'h0F3, 9, 1'b1, 1'b1, 2, 2'b01, NB);
    check("o_stop2_dout", 32'(dout_c), 32'h0F3);
    check("o_stop2_perr", 32'(perr_c), 32'h0);
    check("o_stop2_ferr", 32'(ferr_c), 32'h1);

    // Break: line low for three frame times
    snap = pops_a;
    @(negedge clk);
    ser[0] = 1'b0;
    idle(3 * 10 * NA);
    ser[0] = 1'b1;
    idle(2 * NA);
    check("brk_pops", 32'(pops_a - snap), 32'h1);
    check("brk_dout", 32'(dout_a), 32'h0);
    check("brk_ferr", 32'(ferr_a), 32'h1);
    send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b11, NA);
    check("brk_next_dout", 32'(dout_a), 32'h5A);
    check("brk_next_ferr", 32'(ferr_a), 32'h0);
    check("brk_next_pops", 32'(pops_a - snap), 32'h2);

    // Glitch shorter than half a bit
    snap = pops_a;
    busy_cnt_a = 0;
    @(negedge clk);
    ser[0] = 1'b0;
    idle(10);
    ser[0] = 1'b1;
    idle(100);
    check("glitch_busy_cycles", 32'(busy_cnt_a), 32'd31);
    check("glitch_pops",  32'(pops_a - snap), 32'h0);
    check("glitch_valid", 32'(vld_a), 32'h0);

    // Overrun: ready low for two frames
    rdy_a = 1'b0;
    snap = ovr_cnt_a;
    send(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b11, NA);
    send(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11, NA);
    check("ovr_valid", 32'(vld_a), 32'h1);
    check("ovr_dout",  32'(dout_a), 32'h11);
    check("ovr_count", 32'(ovr_cnt_a - snap), 32'h1);
    check("ovr_when",  32'(ovr_cyc_a - last_e0), 32'(LAT_A));
    rdy_a = 1'b1;
    idle(1);
    rdy_a = 1'b0;
    idle(1);
    check("ovr_popped", 32'(vld_a), 32'h0);

    // Pop coinciding with the completion edge: no overrun, new word loaded
    snap = ovr_cnt_a;
    send(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b11, NA);
    snap2 = pops_a;
    pop_armed = 1'b1;
    send(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11, NA);
    pop_armed = 1'b0;
    check("popsame_ovr",   32'(ovr_cnt_a - snap), 32'h0);
    check("popsame_dout",  32'(dout_a), 32'h22);
    check("popsame_valid", 32'(vld_a), 32'h1);
    check("popsame_pops",  32'(pops_a - snap2), 32'h1);
    rdy_a = 1'b1;
    idle(2);

    // Reset during DATA with the line low at release
    snap = pops_a;
    @(negedge clk);
    ser[0] = 1'b0;
    idle(3 * NA);
    check("rstmid_busy", 32'(busy_a), 32'h1);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(4 * NA);
    ser[0] = 1'b1;
    idle(3 * NA);
    check("rstmid_pops",  32'(pops_a - snap), 32'h0);
    check("rstmid_valid", 32'(vld_a), 32'h0);
    send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b11, NA);
    check("rstmid_next_dout", 32'(dout_a), 32'h3C);
    check("rstmid_next_perr", 32'(perr_a), 32'h0);
    check("rstmid_next_ferr", 32'(ferr_a), 32'h0);
    check("rstmid_next_pops", 32'(pops_a - snap), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver inside `uart_top`. It supports configurable data width, parity mode and stop-bit count. Each received frame carries per-frame parity and framing status. Received words are delivered through a one-entry valid/ready holding register with overrun detection. It sits between the board-level serial pin and any byte-consuming logic on the receive clock domain.

## Interface
- `NUM_CLKS_PER_BIT`, 62: clock cycles per serial bit (clk frequency / baud); legal ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal 5..9.
- `PARITY_MODE`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `clk`  in  1  receive clock; all logic on rising edge. One clock only.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_serial`  in  1  asynchronous serial line, idle high.
- `rx_dout`  out  DATA_BITS  received word; bit i = i-th data bit after start (LSB first).
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts word when `rx_valid && rx_ready`.
- `parity_err`  out  1  parity mismatch for the word in `rx_dout`; 0 when PARITY_MODE=0.
- `frame_err`  out  1  any stop bit of the word in `rx_dout` sampled 0.
- `overrun_err`  out  1  one-cycle pulse: completed frame dropped because the register was full.
- `rx_busy`  out  1  high in START/DATA/PARITY/STOP.

## Operation
- `rx_serial` passes through a 2-flop synchroniser (both flops reset to 1); all logic uses its output `s`.
- MID = (NUM_CLKS_PER_BIT-1)/2 (integer). `cnt` is the bit-time counter and `idx` is the bit index, sized by $clog2.
- State WAIT_HIGH (reset state): go to IDLE when s=1. This prevents a false start after reset or a break.
- IDLE: when s=0, go to START with cnt=0.
- START: increment cnt. At cnt==MID, go to DATA (cnt=0, idx=0) if s=0; otherwise return to IDLE as a glitch.
- DATA: increment cnt. At cnt==NUM_CLKS_PER_BIT-1, take a sample: shift s into bit idx, set cnt=0, increment idx. After DATA_BITS samples, go to PARITY (or STOP if PARITY_MODE=0).
- PARITY: take one sample at the same point. err = ^data ^ p for even parity and ~(^data ^ p) for odd.
- STOP: take STOP_BITS samples at the same point. frame_err is set if any sample is 0.
- On the edge of the last stop sample:
  - Load `rx_dout`, `parity_err` and `frame_err`, and set `rx_valid`.
  - Next state is WAIT_HIGH if frame_err and data==0 (break). Otherwise next state is IDLE.
- Holding register:
  - `rx_valid` clears on the edge where `rx_valid && rx_ready`.
  - If a frame completes while the register is full and not being popped that cycle: the new frame is discarded, the old word and flags are kept, and `overrun_err` goes high for exactly one cycle.
  - If a pop and a completion occur on the same edge: the new word is loaded, `rx_valid` stays 1, and there is no overrun.
- Reset mid-frame: the frame is abandoned and all state is cleared. No `rx_valid` is issued until the line has been seen high and a full new frame has been received.
- Illegal parameter values cause an elaboration-time $error.

## Timing
- Reset values: `rx_dout`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0, `rx_busy`=0, state=WAIT_HIGH.
- Edge 0 is the first clk edge at which `rx_serial` is low. Relative to it:
  - START is entered at edge 2.
  - DATA is entered at edge 3+MID.
  - Sample k (k=1..F, with F = DATA_BITS + parity bits + STOP_BITS) is taken at edge 3+MID+k·NUM_CLKS_PER_BIT.
- `rx_valid` is high after edge 3+MID+F·NUM_CLKS_PER_BIT. For the defaults (8N1): 3+30+9·62 = 591.
- Status flags are registered with the data and change only on a load edge.
- `rx_busy` falls on the same edge that `rx_valid` rises.
- The receiver is ready for the next start edge in the cycle after that load edge, i.e. about half a bit before the nominal end of the stop bit.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP.
  - Constants `PARITY_NONE`/`PARITY_EVEN`/`PARITY_ODD`.
  - Function `uart_frame_bits(data, parity, stop)`.
- Sub-module `uart_sync`: 2-flop synchroniser, parametrised reset value (1 here), reusable by the transmitter-side loopback.

## Test plan
- 8N1, NUM_CLKS_PER_BIT=62, send 0xA5, rx_ready=1 -> `rx_valid` high 591 cycles after edge 0, `rx_dout`=0xA5, all error flags 0, single-cycle valid.
- 8E1:
  - Send 0x07 with parity bit 1 -> `parity_err`=0.
  - Send 0x07 with parity bit 0 -> `rx_dout`=0x07, `parity_err`=1.
  - Repeat as 9O2 with data 0x1FF, correct parity -> `rx_dout`=0x1FF, no errors.
- Break: hold line low for 3 frame times -> exactly one `rx_valid` (data 0, `frame_err`=1). Release high, then send 0x5A -> received cleanly.
- Overrun:
  - rx_ready=0, send 0x11 then 0x22 -> `rx_dout` stays 0x11 and `overrun_err` pulses once at the end of frame 2.
  - Repeat with a pop timed on the completion edge -> no pulse, `rx_dout`=0x22.
- Glitch: line low for 10 cycles (< MID) -> return to IDLE, no `rx_valid`, `rx_busy` drops after MID+1 cycles.
- Assert `rst` during DATA of a frame, with the line low at release -> no `rx_valid` for that frame. The next full frame 0x3C is received correctly with no errors.
